// File: rtl/can_ifc_wb_multi.sv
// ---------------------------------------------------------------------------
// can_ifc_wb_multi : Wishbone classic slave fanning out to NUM_CH CAN register
// banks, with global IRQ pending/mask and per-channel reset registers. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module can_ifc_wb_multi #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2,
  parameter int RD_LAT = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [CH_W+8:0]        wb_adr_i,
  input  logic [7:0]             wb_dat_i,
  output logic [7:0]             wb_dat_o,
  input  logic                   wb_cyc_i,
  input  logic                   wb_stb_i,
  input  logic                   wb_we_i,
  output logic                   wb_ack_o,
  output logic [NUM_CH-1:0]      reg_re_o,
  output logic [NUM_CH-1:0]      reg_we_o,
  output logic [NUM_CH-1:0]      reg_rst_o,
  output logic [7:0]             reg_addr_o,
  output logic [7:0]             reg_data_in_o,
  input  logic [NUM_CH*8-1:0]    reg_data_out_i,
  input  logic [NUM_CH-1:0]      irq_on_i,
  output logic                   irq_on_o
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACC = 2'd1, S_WAIT = 2'd2, S_ACK = 2'd3} state_t;

  localparam int WAIT_INIT = (RD_LAT > 1) ? RD_LAT - 2 : 0;

  state_t              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                glob_q, glob_d;
  logic                we_q, we_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [7:0]          addr_q, addr_d;
  logic [7:0]          wdat_q, wdat_d;
  logic [7:0]          rdat_q, rdat_d;
  logic                ack_q, ack_d;
  logic [NUM_CH-1:0]   re_q, re_d;
  logic [NUM_CH-1:0]   wstb_q, wstb_d;
  logic [NUM_CH-1:0]   mask_q, mask_d;
  logic [NUM_CH-1:0]   chrst_q, chrst_d;
  logic                irq_q, irq_d;

  logic                accept;
  logic                mapped;
  logic [NUM_CH-1:0]   pend;
  logic [7:0]          ch_rdata;
  logic [7:0]          glob_rdata;

  assign pend   = ~irq_on_i;
  assign accept = (state_q == S_IDLE) && wb_cyc_i && wb_stb_i;
  assign mapped = !glob_q && (int'(ch_q) < NUM_CH);

  // Unmapped channel indices fall through every compare and read as zero.
  always_comb begin
    ch_rdata = 8'h00;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_q == CH_W'(c)) ch_rdata = reg_data_out_i[8*c +: 8];
    end
  end

  always_comb begin
    case (addr_q)
      8'h00:   glob_rdata = 8'(pend);
      8'h01:   glob_rdata = 8'(mask_q);
      8'h02:   glob_rdata = 8'(chrst_q);
      default: glob_rdata = 8'h00;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    glob_d  = glob_q;
    we_d    = we_q;
    ch_d    = ch_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
    ack_d   = 1'b0;
    re_d    = '0;
    wstb_d  = '0;
    mask_d  = mask_q;
    chrst_d = chrst_q;
    irq_d   = ~|(pend & mask_q);
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_ACC;
          glob_d  = wb_adr_i[CH_W+8];
          ch_d    = wb_adr_i[CH_W+7:8];
          addr_d  = wb_adr_i[7:0];
          wdat_d  = wb_dat_i;
          we_d    = wb_we_i;
          for (int c = 0; c < NUM_CH; c++) begin
            if (!wb_adr_i[CH_W+8] && (wb_adr_i[CH_W+7:8] == CH_W'(c))) begin
              re_d[c]   = !wb_we_i;
              wstb_d[c] = wb_we_i;
            end
          end
        end
      end
      S_ACC: begin
        if (!wb_cyc_i) begin
          state_d = S_IDLE;
        end else if (we_q) begin
          if (glob_q) begin
            case (addr_q)
              8'h01:   mask_d  = wdat_q[NUM_CH-1:0];
              8'h02:   chrst_d = wdat_q[NUM_CH-1:0];
              default: ;
            endcase
          end
          state_d = S_ACK;
          ack_d   = 1'b1;
        end else if (mapped && (RD_LAT > 1)) begin
          state_d = S_WAIT;
          cnt_d   = 2'(WAIT_INIT);
        end else begin
          rdat_d  = glob_q ? glob_rdata : ch_rdata;
          state_d = S_ACK;
          ack_d   = 1'b1;
        end
      end
      S_WAIT: begin
        if (!wb_cyc_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == 2'd0) begin
          rdat_d  = ch_rdata;
          state_d = S_ACK;
          ack_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      glob_q  <= 1'b0;
      we_q    <= 1'b0;
      ch_q    <= '0;
      addr_q  <= 8'h00;
      wdat_q  <= 8'h00;
      rdat_q  <= 8'h00;
      ack_q   <= 1'b0;
      re_q    <= '0;
      wstb_q  <= '0;
      mask_q  <= '1;
      chrst_q <= '0;
      irq_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      glob_q  <= glob_d;
      we_q    <= we_d;
      ch_q    <= ch_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      ack_q   <= ack_d;
      re_q    <= re_d;
      wstb_q  <= wstb_d;
      mask_q  <= mask_d;
      chrst_q <= chrst_d;
      irq_q   <= irq_d;
    end
  end

  assign wb_ack_o      = ack_q;
  assign wb_dat_o      = rdat_q;
  assign reg_re_o      = re_q;
  assign reg_we_o      = wstb_q;
  assign reg_addr_o    = addr_q;
  assign reg_data_in_o = wdat_q;
  assign irq_on_o      = irq_q;
  // Channels are held in reset for as long as the interface itself is.
  assign reg_rst_o     = chrst_q | {NUM_CH{~rst_i}};

endmodule

`default_nettype wire

// File: tb/tb_can_ifc_wb_multi.sv
// ---------------------------------------------------------------------------
// tb_can_ifc_wb_multi : directed bench for can_ifc_wb_multi (4-ch RD_LAT=3
// instance plus a 3-ch RD_LAT=1 instance sharing the bus). Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_can_ifc_wb_multi;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [10:0] wb_adr = '0;
  logic [7:0]  wb_dat = '0;
  logic        wb_cyc = 1'b0;
  logic        wb_we = 1'b0;
  logic        stb_a = 1'b0;
  logic        stb_b = 1'b0;

  logic [7:0]  dat_a, dat_b;
  logic        ack_a, ack_b;
  logic [3:0]  re_a, we_a, rst_a;
  logic [2:0]  re_b, we_b, rst_b;
  logic [7:0]  raddr_a, rdin_a, raddr_b, rdin_b;
  logic [31:0] rdo_a = {8'h44, 8'h33, 8'hC3, 8'h11};
  logic [23:0] rdo_b = {8'h77, 8'h66, 8'hA5};
  logic [3:0]  irq_in_a = 4'b1111;
  logic [2:0]  irq_in_b = 3'b111;
  logic        irq_a, irq_b;

  int checks = 0;
  int errors = 0;

  int         re_cnt_a = 0, we_cnt_a = 0, re_cnt_b = 0;
  logic [3:0] re_last_a = '0, we_last_a = '0;
  logic [7:0] we_addr_a = '0, we_data_a = '0;

  always #5 clk = ~clk;

  can_ifc_wb_multi #(.NUM_CH(4), .CH_W(2), .RD_LAT(3)) u_dut (
    .clk_i(clk), .rst_i(rst_n), .wb_adr_i(wb_adr), .wb_dat_i(wb_dat), .wb_dat_o(dat_a),
    .wb_cyc_i(wb_cyc), .wb_stb_i(stb_a), .wb_we_i(wb_we), .wb_ack_o(ack_a),
    .reg_re_o(re_a), .reg_we_o(we_a), .reg_rst_o(rst_a), .reg_addr_o(raddr_a),
    .reg_data_in_o(rdin_a), .reg_data_out_i(rdo_a), .irq_on_i(irq_in_a), .irq_on_o(irq_a)
  );

  can_ifc_wb_multi #(.NUM_CH(3), .CH_W(2), .RD_LAT(1)) u_dut3 (
    .clk_i(clk), .rst_i(rst_n), .wb_adr_i(wb_adr), .wb_dat_i(wb_dat), .wb_dat_o(dat_b),
    .wb_cyc_i(wb_cyc), .wb_stb_i(stb_b), .wb_we_i(wb_we), .wb_ack_o(ack_b),
    .reg_re_o(re_b), .reg_we_o(we_b), .reg_rst_o(rst_b), .reg_addr_o(raddr_b),
    .reg_data_in_o(rdin_b), .reg_data_out_i(rdo_b), .irq_on_i(irq_in_b), .irq_on_o(irq_b)
  );

  // Strobe monitor: counts strobe-active cycles and records the last pattern seen.
  always @(negedge clk) begin
    if (|re_a) begin re_cnt_a++; re_last_a = re_a; end
    if (|we_a) begin we_cnt_a++; we_last_a = we_a; we_addr_a = raddr_a; we_data_a = rdin_a; end
    if (|re_b) re_cnt_b++;
  end

  // Cycle 0 is the cycle in which stb is first high; ack_cyc = -1 on timeout.
  task automatic wb_xfer(input bit sel, input logic [10:0] adr, input logic we,
                         input logic [7:0] dat, output logic [7:0] rd, output int ack_cyc);
    ack_cyc = -1;
    rd = 8'h00;
    @(negedge clk);
    wb_adr = adr; wb_we = we; wb_dat = dat; wb_cyc = 1'b1;
    if (sel) stb_b = 1'b1; else stb_a = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if ((sel ? ack_b : ack_a) === 1'b1) begin
        ack_cyc = n;
        rd = sel ? dat_b : dat_a;
        break;
      end
    end
    wb_cyc = 1'b0; stb_a = 1'b0; stb_b = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] rd; int ac;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (ack_a !== 1'b0 || dat_a !== 8'h00) begin errors++; $display("FAIL reset_wb ack=%b dat=%h req 0/00", ack_a, dat_a); end
    checks++; if (re_a !== 4'b0 || we_a !== 4'b0) begin errors++; $display("FAIL reset_strb re=%b we=%b req 0000", re_a, we_a); end
    checks++; if (raddr_a !== 8'h00 || rdin_a !== 8'h00) begin errors++; $display("FAIL reset_regbus addr=%h din=%h req 00", raddr_a, rdin_a); end
    checks++; if (irq_a !== 1'b1 || rst_a !== 4'b1111) begin errors++; $display("FAIL reset_irq_rst irq=%b rst=%b req 1/1111", irq_a, rst_a); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (rst_a !== 4'b0000) begin errors++; $display("FAIL rst_release reg_rst=%b req 0000", rst_a); end
    wb_xfer(0, 11'h401, 1'b0, 8'h00, rd, ac);
    checks++; if (rd !== 8'h0F || ac !== 2) begin errors++; $display("FAIL reset_mask rd=%h cyc=%0d req 0f/2", rd, ac); end
  endtask

  task automatic test_ch_write();
    logic [7:0] rd; int ac; int w0, r0;
    w0 = we_cnt_a; r0 = re_cnt_a;
    wb_xfer(0, 11'h207, 1'b1, 8'h5A, rd, ac);
    checks++; if (ac !== 2) begin errors++; $display("FAIL wr_ack_cycle got %0d req 2", ac); end
    checks++; if (we_cnt_a - w0 !== 1 || we_last_a !== 4'b0100) begin errors++; $display("FAIL wr_strobe cnt=%0d pat=%b req 1/0100", we_cnt_a - w0, we_last_a); end
    checks++; if (we_addr_a !== 8'h07 || we_data_a !== 8'h5A) begin errors++; $display("FAIL wr_bus addr=%h data=%h req 07/5a", we_addr_a, we_data_a); end
    checks++; if (re_cnt_a !== r0) begin errors++; $display("FAIL wr_no_re re pulses=%0d req 0", re_cnt_a - r0); end
    repeat (2) @(negedge clk);
    checks++; if (raddr_a !== 8'h07 || rdin_a !== 8'h5A) begin errors++; $display("FAIL wr_hold addr=%h data=%h req 07/5a", raddr_a, rdin_a); end
  endtask

  task automatic test_ch_read();
    logic [7:0] rd; int ac; int r0;
    r0 = re_cnt_a;
    wb_xfer(0, 11'h110, 1'b0, 8'h00, rd, ac);
    checks++; if (ac !== 4) begin errors++; $display("FAIL rd_ack_cycle got %0d req 4", ac); end
    checks++; if (rd !== 8'hC3) begin errors++; $display("FAIL rd_data got %h req c3", rd); end
    checks++; if (re_cnt_a - r0 !== 1 || re_last_a !== 4'b0010) begin errors++; $display("FAIL rd_strobe cnt=%0d pat=%b req 1/0010", re_cnt_a - r0, re_last_a); end
    checks++; if (raddr_a !== 8'h10) begin errors++; $display("FAIL rd_addr got %h req 10", raddr_a); end
  endtask

  task automatic test_irq();
    logic [7:0] rd; int ac;
    irq_in_a = 4'b1101;
    @(negedge clk);
    checks++; if (irq_a !== 1'b0) begin errors++; $display("FAIL irq_assert got %b req 0", irq_a); end
    wb_xfer(0, 11'h400, 1'b0, 8'h00, rd, ac);
    checks++; if (rd !== 8'h02 || ac !== 2) begin errors++; $display("FAIL irq_pend rd=%h cyc=%0d req 02/2", rd, ac); end
    wb_xfer(0, 11'h401, 1'b1, 8'h0D, rd, ac);
    checks++; if (ac !== 2 || irq_a !== 1'b0) begin errors++; $display("FAIL mask_wr cyc=%0d irq=%b req 2/0", ac, irq_a); end
    @(negedge clk);
    checks++; if (irq_a !== 1'b1) begin errors++; $display("FAIL irq_masked got %b req 1", irq_a); end
    wb_xfer(0, 11'h400, 1'b1, 8'hFF, rd, ac);
    wb_xfer(0, 11'h400, 1'b0, 8'h00, rd, ac);
    checks++; if (rd !== 8'h02) begin errors++; $display("FAIL pend_ro got %h req 02", rd); end
    wb_xfer(0, 11'h401, 1'b0, 8'h00, rd, ac);
    checks++; if (rd !== 8'h0D) begin errors++; $display("FAIL mask_rb got %h req 0d", rd); end
  endtask

  task automatic test_unmapped();
    logic [7:0] rd; int ac; int r0;
    r0 = re_cnt_b;
    wb_xfer(1, 11'h307, 1'b0, 8'h00, rd, ac);
    checks++; if (ac !== 2 || rd !== 8'h00) begin errors++; $display("FAIL unmap_rd cyc=%0d rd=%h req 2/00", ac, rd); end
    checks++; if (re_cnt_b !== r0) begin errors++; $display("FAIL unmap_strobe pulses=%0d req 0", re_cnt_b - r0); end
    wb_xfer(1, 11'h003, 1'b0, 8'h00, rd, ac);
    checks++; if (ac !== 2 || rd !== 8'hA5 || re_cnt_b - r0 !== 1) begin errors++; $display("FAIL lat1_rd cyc=%0d rd=%h pulses=%0d req 2/a5/1", ac, rd, re_cnt_b - r0); end
    wb_xfer(0, 11'h405, 1'b0, 8'h00, rd, ac);
    checks++; if (ac !== 2 || rd !== 8'h00) begin errors++; $display("FAIL glob_unmap cyc=%0d rd=%h req 2/00", ac, rd); end
  endtask

  task automatic test_rst_mid();
    logic [7:0] rd; int ac; int seen;
    wb_xfer(0, 11'h402, 1'b1, 8'h01, rd, ac);
    @(negedge clk);
    checks++; if (rst_a !== 4'b0001) begin errors++; $display("FAIL chrst_wr got %b req 0001", rst_a); end
    @(negedge clk);
    wb_adr = 11'h100; wb_we = 1'b0; wb_cyc = 1'b1; stb_a = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (rst_a !== 4'b1111 || ack_a !== 1'b0) begin errors++; $display("FAIL rst_mid rst=%b ack=%b req 1111/0", rst_a, ack_a); end
    wb_cyc = 1'b0; stb_a = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (5) begin @(negedge clk); if (ack_a !== 1'b0) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rst_no_ack acks=%0d req 0", seen); end
    checks++; if (rst_a !== 4'b0000) begin errors++; $display("FAIL rst_chrst_clr got %b req 0000", rst_a); end
    wb_xfer(0, 11'h401, 1'b0, 8'h00, rd, ac);
    checks++; if (rd !== 8'h0F) begin errors++; $display("FAIL rst_mask got %h req 0f", rd); end
  endtask

  task automatic test_abort();
    logic [7:0] rd; int ac; int seen;
    @(negedge clk);
    wb_adr = 11'h100; wb_we = 1'b0; wb_cyc = 1'b1; stb_a = 1'b1;
    repeat (2) @(negedge clk);
    wb_cyc = 1'b0; stb_a = 1'b0;
    seen = 0;
    repeat (4) begin @(negedge clk); if (ack_a !== 1'b0) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_ack acks=%0d req 0", seen); end
    wb_xfer(0, 11'h100, 1'b0, 8'h00, rd, ac);
    checks++; if (ac !== 4 || rd !== 8'hC3) begin errors++; $display("FAIL abort_next cyc=%0d rd=%h req 4/c3", ac, rd); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rd; int ac; int w0;
    w0 = we_cnt_a;
    wb_xfer(0, 11'h0AA, 1'b1, 8'h3C, rd, ac);
    wb_xfer(0, 11'h3BB, 1'b1, 8'hE1, rd, ac);
    checks++; if (we_cnt_a - w0 !== 2 || we_last_a !== 4'b1000 || we_addr_a !== 8'hBB || we_data_a !== 8'hE1) begin
      errors++; $display("FAIL b2b_wr cnt=%0d pat=%b addr=%h data=%h req 2/1000/bb/e1", we_cnt_a - w0, we_last_a, we_addr_a, we_data_a); end
    // Hold stb through the ACK cycle: no second transfer may start from ACK.
    w0 = we_cnt_a;
    @(negedge clk);
    wb_adr = 11'h011; wb_we = 1'b1; wb_dat = 8'h99; wb_cyc = 1'b1; stb_a = 1'b1;
    repeat (3) @(negedge clk);
    wb_cyc = 1'b0; stb_a = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (we_cnt_a - w0 !== 1) begin errors++; $display("FAIL ack_hold pulses=%0d req 1", we_cnt_a - w0); end
  endtask

  initial begin
    #2;
    test_reset();
    test_ch_write();
    test_ch_read();
    test_irq();
    test_unmapped();
    test_rst_mid();
    test_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/can_ifc_wb_multi.md
CAN_IFC_WB_MULTI -- requirements
Module: can_ifc_wb_multi

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of attached can_top_raw channels (legal 1..8).
REQ-002 SHALL have parameter CH_W, default 2, channel-index address width, with 2**CH_W >= NUM_CH.
REQ-003 SHALL have parameter RD_LAT, default 2, channel register read latency in clocks (legal 1..4).
REQ-004 SHALL have port clk_i, input, 1, the single clock for all logic.
REQ-005 SHALL have port rst_i, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port wb_adr_i, input, 1+CH_W+8: bit [CH_W+8] is 1 for global space, 0 for channel space; [CH_W+7:8] is the channel index; [7:0] is the register offset.
REQ-007 SHALL have ports wb_dat_i (input, 8), wb_dat_o (output, 8), wb_cyc_i, wb_stb_i, wb_we_i (inputs, 1) and wb_ack_o (output, 1), forming a Wishbone classic slave.
REQ-008 SHALL have ports reg_re_o, reg_we_o and reg_rst_o, outputs, NUM_CH each: per-channel read strobe, write strobe and reset.
REQ-009 SHALL have ports reg_addr_o (output, 8) and reg_data_in_o (output, 8), shared by all channels.
REQ-010 SHALL have port reg_data_out_i, input, NUM_CH*8: channel c read data on bits [8c+7:8c].
REQ-011 SHALL have ports irq_on_i (input, NUM_CH, per-channel active-low IRQ) and irq_on_o (output, 1, aggregated active-low IRQ).

Function
REQ-012 SHALL implement an FSM with states IDLE, ACC, WAIT and ACK.
REQ-013 IDLE: on wb_cyc_i & wb_stb_i, SHALL latch address, data and we, and go to ACC; transfers SHALL be accepted only in IDLE.
REQ-014 ACC, channel read: SHALL pulse reg_re_o[ch] for exactly 1 cycle, then go to WAIT, or to ACK if RD_LAT=1.
REQ-015 ACC, channel write: SHALL pulse reg_we_o[ch] for exactly 1 cycle, then go to ACK.
REQ-016 WAIT SHALL last RD_LAT-1 cycles, counted by an internal counter.
REQ-017 Read data: reg_data_out_i[ch] SHALL be captured into wb_dat_o on the edge leaving the last ACC/WAIT cycle.
REQ-018 ACK SHALL assert wb_ack_o for exactly 1 cycle, then go to IDLE.
REQ-019 Latency with stb first sampled at the end of cycle 0: write ack in cycle 2; channel read ack in cycle RD_LAT+1; global or unmapped access ack in cycle 2.
REQ-020 reg_addr_o and reg_data_in_o SHALL be registered, updated on accept, and held until the next accept.
REQ-021 Unmapped channel index (>= NUM_CH): no strobe SHALL be issued; reads SHALL return 0x00; writes SHALL be ignored; the access SHALL still be acked.
REQ-022 Global register 0x00 IRQ_PEND, read-only: bit c = ~irq_on_i[c]; writes ignored.
REQ-023 Global register 0x01 IRQ_MASK, read/write: bit c enables channel c.
REQ-024 Global register 0x02 CH_RST, read/write: reg_rst_o[c] = CH_RST[c] | ~rst_i (combinational OR with reset).
REQ-025 Global register bits [7:NUM_CH] SHALL read 0; other global offsets SHALL read 0x00 and ignore writes.
REQ-026 irq_on_o SHALL be registered: ~|(IRQ_PEND & IRQ_MASK), with 1-cycle latency.
REQ-027 wb_cyc_i low in ACC or WAIT SHALL abort to IDLE next cycle with no ack; a strobe already issued is not retracted.
REQ-028 A strobe held high in the ACK cycle SHALL NOT start a new transfer until IDLE.

Reset
REQ-029 While rst_i = 0, SHALL force: FSM to IDLE, wb_ack_o = 0, wb_dat_o = 0x00, reg_re_o = 0, reg_we_o = 0, reg_addr_o = 0x00, reg_data_in_o = 0x00, IRQ_MASK = all ones, CH_RST = 0, irq_on_o = 1, reg_rst_o = all ones.
REQ-030 Reset asserted mid-transfer SHALL abort the transfer immediately, with no ack after release.

Verification
REQ-031 Write 0x5A to channel 2, offset 0x07 -> reg_we_o = 0b0100 for 1 cycle with reg_addr_o = 0x07 and reg_data_in_o = 0x5A; ack in cycle 2.
REQ-032 RD_LAT=3, channel 1 returns 0xC3 -> reg_re_o[1] pulses once; wb_dat_o = 0xC3; ack in cycle 4.
REQ-033 irq_on_i = 0b1101, IRQ_MASK = 0x0F -> IRQ_PEND reads 0x02 and irq_on_o = 0; write IRQ_MASK = 0x0D -> irq_on_o = 1 one cycle later.
REQ-034 NUM_CH=3, read channel index 3 -> no reg_re_o pulse; data 0x00; ack in cycle 2.
REQ-035 Write CH_RST = 0x01 -> reg_rst_o = 0b0001; apply rst_i low during WAIT -> no ack and reg_rst_o = 0b1111.
REQ-036 Drop wb_cyc_i during WAIT -> FSM in IDLE next cycle; wb_ack_o stays 0; the next transfer completes normally.
